// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: opcode and FSM state enums, flag bit positions.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'd0,
      OP_OR  = 4'd1,
      OP_ADD = 4'd2,
      OP_SUB = 4'd3,
      OP_MUL = 4'd4,
      OP_DIV = 4'd5,
      OP_SHR = 4'd6,
      OP_SHL = 4'd7,
      OP_ROR = 4'd8,
      OP_ROL = 4'd9,
      OP_NEG = 4'd10,
      OP_NOT = 4'd11
   } alu_op_e;

   // flags = {Z, N, CO, V, ERR}
   localparam int unsigned FLG_ERR = 0;
   localparam int unsigned FLG_V   = 1;
   localparam int unsigned FLG_CO  = 2;
   localparam int unsigned FLG_N   = 3;
   localparam int unsigned FLG_Z   = 4;
   localparam int unsigned FLG_W   = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_DONE
   } state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one adder.
// Divider path present only when ALU_SEQ_DIV_EN is defined.
module alu_seq_muldiv
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             iter,
`ifdef ALU_SEQ_DIV_EN
   input  logic             op_div,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] b_r;
   logic [WIDTH:0]   add_x;
   logic [WIDTH:0]   add_y;
   logic [WIDTH:0]   add_s;
   logic             add_ci;
   logic [WIDTH-1:0] hi_n;
   logic [WIDTH-1:0] lo_n;
`ifdef ALU_SEQ_DIV_EN
   logic             div_r;
`endif

   always_comb begin
      add_x  = {1'b0, hi};
      add_y  = lo[0] ? {1'b0, b_r} : '0;
      add_ci = 1'b0;
`ifdef ALU_SEQ_DIV_EN
      if (div_r) begin
         add_x  = {hi, lo[WIDTH-1]};
         add_y  = ~{1'b0, b_r};
         add_ci = 1'b1;
      end
`endif
   end

   assign add_s = add_x + add_y + {{WIDTH{1'b0}}, add_ci};

   // MUL: {HI,LO} shifts right with the sum; DIV: sign of the trial difference picks the quotient bit
   always_comb begin
      hi_n = add_s[WIDTH:1];
      lo_n = {add_s[0], lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
      if (div_r) begin
         hi_n = add_s[WIDTH] ? add_x[WIDTH-1:0] : add_s[WIDTH-1:0];
         lo_n = {lo[WIDTH-2:0], ~add_s[WIDTH]};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi    <= '0;
         lo    <= '0;
         b_r   <= '0;
`ifdef ALU_SEQ_DIV_EN
         div_r <= 1'b0;
`endif
      end else if (load) begin
         hi    <= '0;
         lo    <= a;
         b_r   <= b;
`ifdef ALU_SEQ_DIV_EN
         div_r <= op_div;
`endif
      end else if (iter) begin
         hi    <= hi_n;
         lo    <= lo_n;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Multicycle ALU: FSM, single-cycle datapath, flags and output registers.
// Define ALU_SEQ_DIV_EN to build the iterative divider; otherwise DIV reports ERR.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] HI,
   output logic [4:0]       flags
);

   state_e           state, state_n;
   logic [SHW-1:0]   cnt, cnt_n;
   alu_op_e          op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             accept, long_op;
   logic [WIDTH-1:0] md_hi, md_lo;

   logic [WIDTH-1:0]   res_c, res_hi;
   logic [FLG_W-1:0]   res_fl;
   logic               co, v, err;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] rot;

   assign busy   = (state != ST_IDLE);
   assign accept = (state == ST_IDLE) && start;
`ifdef ALU_SEQ_DIV_EN
   assign long_op = (op == OP_MUL) || ((op == OP_DIV) && (B != '0));
`else
   assign long_op = (op == OP_MUL);
`endif

   alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept),
      .iter   (state == ST_ITER),
`ifdef ALU_SEQ_DIV_EN
      .op_div (op == OP_DIV),
`endif
      .a      (A),
      .b      (B),
      .hi     (md_hi),
      .lo     (md_lo)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         ST_IDLE: if (start) begin
            if (long_op) begin
               state_n = ST_ITER;
               cnt_n   = SHW'(WIDTH - 1);
            end else begin
               state_n = ST_DONE;
            end
         end
         ST_ITER: if (cnt == '0) state_n = ST_DONE;
                  else cnt_n = cnt - 1'b1;
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      res_c  = '0;
      res_hi = '0;
      co     = 1'b0;
      v      = 1'b0;
      err    = 1'b0;
      sum    = '0;
      rot    = '0;
      case (op_q)
         OP_AND: res_c = a_q & b_q;
         OP_OR:  res_c = a_q | b_q;
         OP_ADD: begin
            sum   = {1'b0, a_q} + {1'b0, b_q};
            res_c = sum[WIDTH-1:0];
            co    = sum[WIDTH];
            v     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_c[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            sum   = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
            res_c = sum[WIDTH-1:0];
            co    = sum[WIDTH];
            v     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_c[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_MUL: begin
            res_c  = md_lo;
            res_hi = md_hi;
         end
`ifdef ALU_SEQ_DIV_EN
         OP_DIV: if (b_q == '0) begin
            res_c  = '1;
            res_hi = a_q;
            err    = 1'b1;
         end else begin
            res_c  = md_lo;
            res_hi = md_hi;
         end
`else
         OP_DIV: err = 1'b1;
`endif
         // any B bit at or above SHW means the amount is >= WIDTH
         OP_SHR: res_c = (|b_q[WIDTH-1:SHW]) ? '0 : (a_q >> b_q[SHW-1:0]);
         OP_SHL: res_c = (|b_q[WIDTH-1:SHW]) ? '0 : (a_q << b_q[SHW-1:0]);
         OP_ROR: begin
            rot   = {a_q, a_q} >> b_q[SHW-1:0];
            res_c = rot[WIDTH-1:0];
         end
         OP_ROL: begin
            rot   = {a_q, a_q} << b_q[SHW-1:0];
            res_c = rot[2*WIDTH-1:WIDTH];
         end
         OP_NEG: begin
            sum   = {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
            res_c = sum[WIDTH-1:0];
            co    = sum[WIDTH];
            v     = (b_q == {1'b1, {(WIDTH-1){1'b0}}});
         end
         OP_NOT: res_c = ~b_q;
         default: err = 1'b1;
      endcase
      res_fl          = '0;
      res_fl[FLG_Z]   = (res_c == '0);
      res_fl[FLG_N]   = res_c[WIDTH-1];
      res_fl[FLG_CO]  = co;
      res_fl[FLG_V]   = v;
      res_fl[FLG_ERR] = err;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         op_q  <= OP_AND;
         a_q   <= '0;
         b_q   <= '0;
         done  <= 1'b0;
         C     <= '0;
         HI    <= '0;
         flags <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         done  <= (state == ST_DONE);
         if (accept) begin
            op_q <= alu_op_e'(op);
            a_q  <= A;
            b_q  <= B;
         end
         if (state == ST_DONE) begin
            C     <= res_c;
            HI    <= res_hi;
            flags <= res_fl;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases, then random ops vs a reference model.
module tb_alu_seq;

   localparam int unsigned W = 32;
   localparam longint MAXS = 64'sh7FFF_FFFF;
   localparam longint MINS = -MAXS - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   op = '0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         busy, done;
   logic [W-1:0] C, HI;
   logic [4:0]   flags;

   alu_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .C     (C),
      .HI    (HI),
      .flags (flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] c;
      logic [W-1:0] hi;
      logic [4:0]   fl;
      int unsigned  lat;
      int unsigned  acc;
      logic [3:0]   op;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      logic [63:0] p;
      longint      sr;
      int unsigned amt;
      bit          co, v, err;
      e.c = '0; e.hi = '0; e.lat = 1; e.acc = 0; e.op = o;
      co = 0; v = 0; err = 0;
      amt = b % W;
      case (o)
         4'd0: e.c = a & b;
         4'd1: e.c = a | b;
         4'd2: begin
            e.c = a + b;
            co  = (64'(a) + 64'(b)) >= 64'h1_0000_0000;
            sr  = longint'($signed(a)) + longint'($signed(b));
            v   = (sr > MAXS) || (sr < MINS);
         end
         4'd3: begin
            e.c = a - b;
            co  = (a >= b);
            sr  = longint'($signed(a)) - longint'($signed(b));
            v   = (sr > MAXS) || (sr < MINS);
         end
         4'd4: begin
            p     = 64'(a) * 64'(b);
            e.c   = p[31:0];
            e.hi  = p[63:32];
            e.lat = W + 1;
         end
         4'd5: begin
`ifdef ALU_SEQ_DIV_EN
            if (b == 0) begin
               e.c = '1; e.hi = a; err = 1;
            end else begin
               e.c = a / b; e.hi = a % b; e.lat = W + 1;
            end
`else
            err = 1;
`endif
         end
         4'd6: e.c = (b >= W) ? '0 : (a >> b);
         4'd7: e.c = (b >= W) ? '0 : (a << b);
         4'd8: e.c = (a >> amt) | (a << (W - amt));
         4'd9: e.c = (a << amt) | (a >> (W - amt));
         4'd10: begin
            e.c = -b;
            co  = (b == 0);
            v   = (b == 32'h8000_0000);
         end
         4'd11: e.c = ~b;
         default: err = 1;
      endcase
      e.fl = {e.c == 0, e.c[W-1], co, v, err};
      return e;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: pops the scoreboard on done, otherwise checks outputs hold their last result.
   logic [W-1:0] last_c = '0, last_hi = '0;
   logic [4:0]   last_fl = '0;
   logic         prev_done = 1'b0;
   exp_t         m_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         last_c = '0; last_hi = '0; last_fl = '0; prev_done = 1'b0;
      end else begin
         if (done) begin
            chk("done_consecutive", W'(prev_done), '0);
            if (sb.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_done: got done=1 with no pending op, expected none");
            end else begin
               m_e = sb.pop_front();
               chk($sformatf("C op%0d", m_e.op), C, m_e.c);
               chk($sformatf("HI op%0d", m_e.op), HI, m_e.hi);
               chk($sformatf("flags op%0d", m_e.op), W'(flags), W'(m_e.fl));
               chk($sformatf("latency op%0d", m_e.op), W'(cyc - m_e.acc), W'(m_e.lat));
               last_c = m_e.c; last_hi = m_e.hi; last_fl = m_e.fl;
            end
         end else begin
            chk("hold_C", C, last_c);
            chk("hold_HI", HI, last_hi);
            chk("hold_flags", W'(flags), W'(last_fl));
         end
         prev_done = done;
      end
   end

   task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      int unsigned n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (busy !== 1'b0) begin
         n_vec++; n_err++;
         $display("FAIL busy_timeout: busy=%b after %0d cycles, expected 0", busy, n);
         return;
      end
      op = o; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      e = model(o, a, b);
      e.acc = cyc;
      sb.push_back(e);
      start = 1'b0;
      chk("busy_after_accept", W'(busy), W'(1));
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return W'($urandom_range(0, 40));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int unsigned n;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", W'(busy), '0);
      chk("rst_done", W'(done), '0);
      chk("rst_C", C, '0);
      chk("rst_HI", HI, '0);
      chk("rst_flags", W'(flags), '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(4'd2, 32'hFFFF_FFFF, 32'd1);
      issue(4'd3, 32'h8000_0000, 32'd1);
      issue(4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (3) begin
         start = 1'b1; op = 4'd2; A = 32'd5; B = 32'd6;
         @(posedge clk); #1;
         start = 1'b0;
         @(posedge clk); #1;
      end
      issue(4'd5, 32'd100, 32'd7);
      issue(4'd5, 32'h0000_1234, 32'd0);
      issue(4'd9, 32'h8000_0001, 32'd36);
      issue(4'd8, 32'h8000_0001, 32'd33);
      issue(4'd7, 32'h1234_5678, 32'd32);
      issue(4'd6, 32'hF000_0000, 32'hFFFF_FFFF);
      issue(4'd6, 32'hF000_0000, 32'd31);
      issue(4'd13, 32'h1, 32'h2);
      issue(4'd10, 32'h0, 32'h8000_0000);
      issue(4'd10, 32'h0, 32'h0);
      issue(4'd11, 32'h0, 32'h0);

      // reset ten cycles into a multiply, then confirm recovery
      issue(4'd4, 32'hDEAD_BEEF, 32'h0001_2345);
      repeat (10) @(posedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", W'(busy), '0);
      chk("midrst_done", W'(done), '0);
      chk("midrst_C", C, '0);
      chk("midrst_HI", HI, '0);
      chk("midrst_flags", W'(flags), '0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(4'd4, 32'h0001_0000, 32'h0003_0000);
      issue(4'd5, 32'hFFFF_FFFF, 32'h0000_0010);

      for (int i = 0; i < 300; i++) begin
         issue(4'($urandom_range(0, 15)), pick(), pick());
      end

      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); n++;
      end
      if (sb.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL drain_timeout: %0d ops pending, expected 0", sb.size());
      end
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
